bus_loader: RTL and testbench

//  Memory-bus initiator that boots a program image into dCPU RAM. Accepts a byte

---
 rtl/bus_loader_if.sv | 24 ++
 rtl/bus_loader.sv | 137 +++++++++++++
 tb/tb_bus_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_loader_if.sv
// rtl/bus_loader_if.sv - byte stream and RAM bus bundle for the program loader
interface bus_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mem_in;
    logic              R;
    logic              W;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_out;

    modport master (
        input  in_data, in_valid, mem_in,
        output in_ready, R, W, addr, data_out
    );

    modport slave (
        output in_data, in_valid, mem_in,
        input  in_ready, R, W, addr, data_out
    );
endinterface

// File: rtl/bus_loader.sv
// rtl/bus_loader.sv - streams a program image into dCPU RAM with optional readback verify
module bus_loader #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter bit VERIFY        = 1'b1,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    bus_loader_if.master      bus,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W-1:0] o_err_addr
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WRITE, S_VERIFY, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_err_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_R;
    logic              r_W;
    logic              r_in_ready;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic [ADDR_W:0]   w_len;
    logic              w_advance;
    logic              w_mismatch;

    // Lengths beyond the RAM depth would only rewrite the same locations.
    assign w_len      = (i_len > DEPTH) ? DEPTH : i_len;
    assign w_advance  = (r_state == S_VERIFY) || ((r_state == S_WRITE) && !VERIFY);
    assign w_mismatch = (r_state == S_VERIFY) && (bus.mem_in != r_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_R        <= 1'b1;
            r_W        <= 1'b1;
            r_in_ready <= 1'b0;
            r_cpu_rst  <= HOLD_ON_RESET;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_addr     <= i_base;
                        r_count    <= w_len;
                        r_error    <= 1'b0;
                        r_err_addr <= '0;
                        r_busy     <= 1'b1;
                        if (w_len == '0) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state    <= S_FETCH;
                            r_in_ready <= 1'b1;
                            r_cpu_rst  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_data     <= bus.in_data;
                        r_in_ready <= 1'b0;
                        r_W        <= 1'b0;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_W <= 1'b1;
                    if (VERIFY) begin
                        r_R     <= 1'b0;
                        r_state <= S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    r_R <= 1'b1;
                    // Only the first mismatch of a load records its address.
                    if (w_mismatch && !r_error) begin
                        r_error    <= 1'b1;
                        r_err_addr <= r_addr;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_advance) begin
                r_count <= r_count - ONE;
                r_addr  <= r_addr + 1'b1;
                if (r_count == ONE) begin
                    r_state   <= S_DONE;
                    r_done    <= 1'b1;
                    r_cpu_rst <= 1'b0;
                end else begin
                    r_state    <= S_FETCH;
                    r_in_ready <= 1'b1;
                end
            end
        end
    end

    assign bus.R        = r_R;
    assign bus.W        = r_W;
    assign bus.addr     = r_addr;
    assign bus.data_out = r_data;
    assign bus.in_ready = r_in_ready;
    assign o_cpu_rst    = r_cpu_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_err_addr   = r_err_addr;
endmodule

// File: tb/tb_bus_loader.sv
// tb/tb_bus_loader.sv - directed bench for bus_loader: verify and no-verify instances on one RAM model
module tb_bus_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       force_bad = 1'b0;
    logic       fill_en = 1'b0;
    logic [7:0] fill_val = 8'h00;
    logic [7:0] base_v = 8'h00;
    logic [8:0] len_v = 9'h000;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;

    logic [7:0] ram    [0:255];
    logic [7:0] stream [0:255];
    logic [7:0] w_log  [0:1023];

    int tot_w = 0, tot_r = 0, tot_rdy = 0, tot_rw0 = 0, tot_cpu_bad = 0;
    int nvec = 0, nbad = 0;
    int t_cyc = 0, t_w = 0, t_r = 0, t_rdy = 0, t_log0 = 0;
    bit t_timeout = 1'b0, t_abort = 1'b0;

    logic       cpu_rst0, busy0, done0, err0;
    logic [7:0] erra0;
    logic       cpu_rst1, busy1, done1, err1;
    logic [7:0] erra1;

    bus_loader_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
    bus_loader_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    assign bus0.in_data  = in_data;
    assign bus0.in_valid = in_valid;
    assign bus0.mem_in   = (force_bad && bus0.addr == 8'h05) ? 8'h00 : ram[bus0.addr];
    assign bus1.in_data  = in_data;
    assign bus1.in_valid = in_valid;
    assign bus1.mem_in   = (force_bad && bus1.addr == 8'h05) ? 8'h00 : ram[bus1.addr];

    bus_loader #(.ADDR_W(8), .DATA_W(8), .VERIFY(1'b1), .HOLD_ON_RESET(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start && !sel), .i_base(base_v), .i_len(len_v),
        .bus(bus0), .o_cpu_rst(cpu_rst0), .o_busy(busy0), .o_done(done0),
        .o_error(err0), .o_err_addr(erra0)
    );

    bus_loader #(.ADDR_W(8), .DATA_W(8), .VERIFY(1'b0), .HOLD_ON_RESET(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start && sel), .i_base(base_v), .i_len(len_v),
        .bus(bus1), .o_cpu_rst(cpu_rst1), .o_busy(busy1), .o_done(done1),
        .o_error(err1), .o_err_addr(erra1)
    );

    logic       cur_W, cur_R, cur_in_ready, cur_busy, cur_done, cur_cpu_rst;
    logic [7:0] cur_addr;
    assign cur_W        = sel ? bus1.W        : bus0.W;
    assign cur_R        = sel ? bus1.R        : bus0.R;
    assign cur_in_ready = sel ? bus1.in_ready : bus0.in_ready;
    assign cur_addr     = sel ? bus1.addr     : bus0.addr;
    assign cur_busy     = sel ? busy1         : busy0;
    assign cur_done     = sel ? done1         : done0;
    assign cur_cpu_rst  = sel ? cpu_rst1      : cpu_rst0;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) ram[i] <= fill_val;
        end else begin
            if (!bus0.W) ram[bus0.addr] <= bus0.data_out;
            if (!bus1.W) ram[bus1.addr] <= bus1.data_out;
        end
    end

    always @(negedge clk) begin
        if (!cur_W) begin
            w_log[tot_w % 1024] = cur_addr;
            tot_w++;
        end
        if (!cur_R) tot_r++;
        if (cur_in_ready) tot_rdy++;
        if ((!bus0.R && !bus0.W) || (!bus1.R && !bus1.W)) tot_rw0++;
        if (cur_busy && !cur_done && !cur_cpu_rst) tot_cpu_bad++;
    end

    task automatic fill_ram(input logic [7:0] v);
        fill_val = v;
        fill_en  = 1'b1;
        @(posedge clk);
        #1 fill_en = 1'b0;
    endtask

    task automatic run_load(input logic s, input logic [7:0] b, input logic [8:0] l, input int n,
                            input bit gap, input int poke_at, input int abort_at_w);
        int idx = 0;
        int wseen = 0;
        bit pend = 1'b0;
        int w0, r0, q0;
        @(negedge clk); #1;
        sel = s;
        w0 = tot_w; r0 = tot_r; q0 = tot_rdy; t_log0 = tot_w;
        t_timeout = 1'b1; t_abort = 1'b0; t_cyc = 0;
        base_v = b; len_v = l; start = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk); #1;
            start = (c == poke_at);
            if (start) begin base_v = 8'h80; len_v = 9'd2; end
            if (pend) idx++;
            t_cyc = c;
            if (cur_done) begin t_timeout = 1'b0; break; end
            if (abort_at_w > 0 && !cur_W) begin
                wseen++;
                if (wseen == abort_at_w) begin
                    rst = 1'b1; #1;
                    t_abort = 1'b1; t_timeout = 1'b0;
                    break;
                end
            end
            in_valid = (idx < n) && (!gap || (c % 2 == 0));
            in_data  = in_valid ? stream[idx] : 8'h00;
            pend     = in_valid && cur_in_ready;
        end
        start = 1'b0; in_valid = 1'b0;
        t_w = tot_w - w0; t_r = tot_r - r0; t_rdy = tot_rdy - q0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        nvec++; if (bus0.R !== 1'b1) begin nbad++; $display("FAIL reset_R got %0h want 1", bus0.R); end
        nvec++; if (bus0.W !== 1'b1) begin nbad++; $display("FAIL reset_W got %0h want 1", bus0.W); end
        nvec++; if (bus0.addr !== 8'h00) begin nbad++; $display("FAIL reset_addr got %0h want 0", bus0.addr); end
        nvec++; if (bus0.data_out !== 8'h00) begin nbad++; $display("FAIL reset_data_out got %0h want 0", bus0.data_out); end
        nvec++; if (bus0.in_ready !== 1'b0) begin nbad++; $display("FAIL reset_in_ready got %0h want 0", bus0.in_ready); end
        nvec++; if (busy0 !== 1'b0) begin nbad++; $display("FAIL reset_busy got %0h want 0", busy0); end
        nvec++; if (done0 !== 1'b0) begin nbad++; $display("FAIL reset_done got %0h want 0", done0); end
        nvec++; if (err0 !== 1'b0) begin nbad++; $display("FAIL reset_error got %0h want 0", err0); end
        nvec++; if (erra0 !== 8'h00) begin nbad++; $display("FAIL reset_err_addr got %0h want 0", erra0); end
        nvec++; if (cpu_rst0 !== 1'b1) begin nbad++; $display("FAIL reset_cpu_rst got %0h want 1", cpu_rst0); end
    endtask

    task automatic test_basic_verify();
        fill_ram(8'h00);
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
        run_load(1'b0, 8'h00, 9'd4, 4, 1'b0, 0, 0);
        nvec++; if (t_timeout !== 1'b0) begin nbad++; $display("FAIL basic_timeout got %0d want 0", t_timeout); end
        nvec++; if (t_cyc != 13) begin nbad++; $display("FAIL basic_cycles got %0d want 13", t_cyc); end
        nvec++; if (cpu_rst0 !== 1'b0) begin nbad++; $display("FAIL basic_cpu_rst_at_done got %0h want 0", cpu_rst0); end
        nvec++; if (err0 !== 1'b0) begin nbad++; $display("FAIL basic_error got %0h want 0", err0); end
        nvec++; if (t_w != 4) begin nbad++; $display("FAIL basic_w_low got %0d want 4", t_w); end
        nvec++; if (t_r != 4) begin nbad++; $display("FAIL basic_r_low got %0d want 4", t_r); end
        nvec++; if (t_rdy != 4) begin nbad++; $display("FAIL basic_ready_cycles got %0d want 4", t_rdy); end
        nvec++; if (ram[0] !== 8'h11) begin nbad++; $display("FAIL basic_ram0 got %0h want 11", ram[0]); end
        nvec++; if (ram[1] !== 8'h22) begin nbad++; $display("FAIL basic_ram1 got %0h want 22", ram[1]); end
        nvec++; if (ram[2] !== 8'h33) begin nbad++; $display("FAIL basic_ram2 got %0h want 33", ram[2]); end
        nvec++; if (ram[3] !== 8'h44) begin nbad++; $display("FAIL basic_ram3 got %0h want 44", ram[3]); end
        @(negedge clk); #1;
        nvec++; if (done0 !== 1'b0) begin nbad++; $display("FAIL basic_done_width got %0h want 0", done0); end
        nvec++; if (busy0 !== 1'b0) begin nbad++; $display("FAIL basic_busy_after got %0h want 0", busy0); end
        nvec++; if (cpu_rst0 !== 1'b0) begin nbad++; $display("FAIL basic_cpu_rst_idle got %0h want 0", cpu_rst0); end
        nvec++; if (tot_cpu_bad != 0) begin nbad++; $display("FAIL basic_cpu_rst_while_busy got %0d want 0", tot_cpu_bad); end
    endtask

    task automatic test_wrap();
        fill_ram(8'h00);
        stream[0] = 8'hAA; stream[1] = 8'hBB; stream[2] = 8'hCC;
        run_load(1'b0, 8'hFE, 9'd3, 3, 1'b0, 0, 0);
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 10) begin nbad++; $display("FAIL wrap_cycles got %0d want 10", t_cyc); end
        nvec++; if (ram[8'hFE] !== 8'hAA) begin nbad++; $display("FAIL wrap_ramFE got %0h want aa", ram[8'hFE]); end
        nvec++; if (ram[8'hFF] !== 8'hBB) begin nbad++; $display("FAIL wrap_ramFF got %0h want bb", ram[8'hFF]); end
        nvec++; if (ram[8'h00] !== 8'hCC) begin nbad++; $display("FAIL wrap_ram00 got %0h want cc", ram[8'h00]); end
        nvec++; if (w_log[(t_log0 + 2) % 1024] !== 8'h00) begin nbad++; $display("FAIL wrap_third_addr got %0h want 0", w_log[(t_log0 + 2) % 1024]); end
    endtask

    task automatic test_verify_error();
        int bad = 0;
        fill_ram(8'h00);
        force_bad = 1'b1;
        for (int i = 0; i < 8; i++) stream[i] = 8'hFF;
        run_load(1'b0, 8'h00, 9'd8, 8, 1'b0, 0, 0);
        force_bad = 1'b0;
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 25) begin nbad++; $display("FAIL verr_done_cycle got %0d want 25", t_cyc); end
        nvec++; if (err0 !== 1'b1) begin nbad++; $display("FAIL verr_error got %0h want 1", err0); end
        nvec++; if (erra0 !== 8'h05) begin nbad++; $display("FAIL verr_err_addr got %0h want 05", erra0); end
        nvec++; if (t_w != 8) begin nbad++; $display("FAIL verr_w_low got %0d want 8", t_w); end
        for (int i = 0; i < 8; i++) if (ram[i] !== 8'hFF) bad++;
        nvec++; if (bad != 0) begin nbad++; $display("FAIL verr_ram got %0d bad bytes want 0", bad); end
        @(negedge clk); #1;
        nvec++; if (err0 !== 1'b1) begin nbad++; $display("FAIL verr_sticky got %0h want 1", err0); end
    endtask

    task automatic test_len0();
        run_load(1'b0, 8'h33, 9'd0, 0, 1'b0, 0, 0);
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 1) begin nbad++; $display("FAIL len0_done_cycle got %0d want 1", t_cyc); end
        nvec++; if (t_w != 0 || t_r != 0) begin nbad++; $display("FAIL len0_bus got w=%0d r=%0d want 0 0", t_w, t_r); end
        nvec++; if (t_rdy != 0) begin nbad++; $display("FAIL len0_ready got %0d want 0", t_rdy); end
        nvec++; if (err0 !== 1'b0) begin nbad++; $display("FAIL len0_error_cleared got %0h want 0", err0); end
        nvec++; if (busy0 !== 1'b1) begin nbad++; $display("FAIL len0_busy_in_done got %0h want 1", busy0); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        fill_ram(8'h00);
        for (int i = 0; i < 6; i++) stream[i] = 8'(8'hA0 + i);
        run_load(1'b1, 8'h40, 9'd6, 6, 1'b1, 5, 0);
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 14) begin nbad++; $display("FAIL b2b_cycles got %0d want 14", t_cyc); end
        nvec++; if (t_rdy != 7) begin nbad++; $display("FAIL b2b_ready_cycles got %0d want 7", t_rdy); end
        nvec++; if (t_r != 0) begin nbad++; $display("FAIL b2b_r_low got %0d want 0", t_r); end
        nvec++; if (t_w != 6) begin nbad++; $display("FAIL b2b_w_low got %0d want 6", t_w); end
        for (int i = 0; i < 6; i++) begin
            if (w_log[(t_log0 + i) % 1024] !== 8'(8'h40 + i)) bad++;
            if (ram[8'h40 + i] !== 8'(8'hA0 + i)) bad++;
        end
        nvec++; if (bad != 0) begin nbad++; $display("FAIL b2b_addr_data got %0d bad want 0", bad); end
        nvec++; if (ram[8'h80] !== 8'h00) begin nbad++; $display("FAIL b2b_ignored_start got %0h want 0", ram[8'h80]); end
        nvec++; if (tot_rw0 != 0) begin nbad++; $display("FAIL b2b_rw_both_low got %0d want 0", tot_rw0); end
        run_load(1'b1, 8'h10, 9'd3, 3, 1'b0, 0, 0);
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 7) begin nbad++; $display("FAIL b2b_throughput got %0d want 7", t_cyc); end
    endtask

    task automatic test_clamp();
        int bad = 0;
        fill_ram(8'h00);
        for (int i = 0; i < 256; i++) stream[i] = 8'(i ^ 8'h5A);
        run_load(1'b1, 8'h10, 9'h1FF, 256, 1'b0, 0, 0);
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 513) begin nbad++; $display("FAIL clamp_cycles got %0d want 513", t_cyc); end
        nvec++; if (t_w != 256) begin nbad++; $display("FAIL clamp_w_low got %0d want 256", t_w); end
        for (int i = 0; i < 256; i++) if (ram[8'(8'h10 + i)] !== 8'(i ^ 8'h5A)) bad++;
        nvec++; if (bad != 0) begin nbad++; $display("FAIL clamp_ram got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        fill_ram(8'hEE);
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03; stream[3] = 8'h04;
        run_load(1'b0, 8'h20, 9'd4, 4, 1'b0, 0, 3);
        nvec++; if (t_abort !== 1'b1) begin nbad++; $display("FAIL rmid_reached_write got %0d want 1", t_abort); end
        nvec++; if (bus0.W !== 1'b1 || bus0.R !== 1'b1) begin nbad++; $display("FAIL rmid_bus_release got R=%0h W=%0h want 1 1", bus0.R, bus0.W); end
        nvec++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin nbad++; $display("FAIL rmid_busy_done got %0h %0h want 0 0", busy0, done0); end
        nvec++; if (bus0.addr !== 8'h00) begin nbad++; $display("FAIL rmid_addr got %0h want 0", bus0.addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        nvec++; if (ram[8'h20] !== 8'h01 || ram[8'h21] !== 8'h02) begin nbad++; $display("FAIL rmid_kept got %0h %0h want 01 02", ram[8'h20], ram[8'h21]); end
        nvec++; if (ram[8'h22] !== 8'hEE) begin nbad++; $display("FAIL rmid_unwritten got %0h want ee", ram[8'h22]); end
        nvec++; if (cpu_rst0 !== 1'b1 || done0 !== 1'b0) begin nbad++; $display("FAIL rmid_after got cpu_rst=%0h done=%0h want 1 0", cpu_rst0, done0); end
        stream[0] = 8'h05; stream[1] = 8'h06; stream[2] = 8'h07; stream[3] = 8'h08;
        run_load(1'b0, 8'h20, 9'd4, 4, 1'b0, 0, 0);
        nvec++; if (t_timeout !== 1'b0 || t_cyc != 13) begin nbad++; $display("FAIL rmid_reload_cycles got %0d want 13", t_cyc); end
        for (int i = 0; i < 4; i++) if (ram[8'h20 + i] !== 8'(5 + i)) bad++;
        nvec++; if (bad != 0) begin nbad++; $display("FAIL rmid_reload_ram got %0d bad want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic_verify();
        test_wrap();
        test_verify_error();
        test_len0();
        test_back_to_back();
        test_clamp();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
